// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: FSM states, the table entry
// layout (at maximum field widths) and counter/PC-field helper functions.
package bp_pkg;

  localparam int CTR_MAX_W = 4;
  localparam int TAG_MAX_W = 28;

  typedef enum logic {
    BP_INIT,
    BP_RUN
  } bp_state_e;

  typedef logic [CTR_MAX_W-1:0] ctr_t;
  typedef logic [TAG_MAX_W-1:0] tag_t;

  // Working form of one table entry; storage keeps only the configured widths.
  typedef struct packed {
    logic        valid;
    tag_t        tag;
    logic [29:0] target;
    ctr_t        ctr;
  } bp_entry_t;

  function automatic ctr_t ctr_max(input int unsigned width);
    return ctr_t'((32'd1 << width) - 32'd1);
  endfunction

  function automatic ctr_t ctr_inc(input ctr_t c, input int unsigned width);
    return (c >= ctr_max(width)) ? c : c + ctr_t'(1);
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    return (c == '0) ? c : c - ctr_t'(1);
  endfunction

  function automatic ctr_t ctr_weak_taken(input int unsigned width);
    return ctr_t'(32'd1 << (width - 1));
  endfunction

  function automatic ctr_t ctr_weak_not_taken(input int unsigned width);
    return ctr_t'((32'd1 << (width - 1)) - 32'd1);
  endfunction

  // Word-aligned PCs: the two low bits never take part in indexing.
  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int unsigned idx_w);
    return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic tag_t pc_tag(input logic [31:0] pc, input int unsigned idx_w,
                                  input int unsigned tag_w);
    return tag_t'((pc >> (idx_w + 2)) & ((32'd1 << tag_w) - 32'd1));
  endfunction

endpackage

// File: rtl/bp_table.sv
// ENTRIES-deep entry store: one registered lookup read port (returns the pre-write
// entry on a same-index collision), one write port, and a combinational peek port
// used by the update read-modify-write.
module bp_table #(
  parameter int ENTRIES = 64,
  parameter int DATA_W  = 32
) (
  input  logic                       clk,
  input  logic                       rd_en_i,
  input  logic [$clog2(ENTRIES)-1:0] rd_idx_i,
  output logic [DATA_W-1:0]          rd_data_o,
  input  logic [$clog2(ENTRIES)-1:0] peek_idx_i,
  output logic [DATA_W-1:0]          peek_data_o,
  input  logic                       wr_en_i,
  input  logic [$clog2(ENTRIES)-1:0] wr_idx_i,
  input  logic [DATA_W-1:0]          wr_data_i
);

  logic [DATA_W-1:0] mem_q [ENTRIES];
  logic [DATA_W-1:0] rd_data_q;

  // NOTE: the array has no reset; the owner clears it entry by entry after reset, and the
  // read register is qualified by a reset valid bit in the owner.
  // NOTE: non-blocking writes mean a same-edge read of the written index returns the old entry.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_idx_i];
    end
  end

  assign rd_data_o   = rd_data_q;
  assign peek_data_o = mem_q[peek_idx_i];

endmodule

// File: rtl/branch_predictor.sv
// BHT + BTB branch predictor: looked up from the IF PC (result one cycle later), trained
// from EX resolution. Define BP_BTB_TAG_EN to store and compare per-entry tags.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int          ENTRIES   = 64,
  parameter int          CTR_WIDTH = 2,
  parameter int          TAG_WIDTH = 8,
  parameter logic [31:0] RESET_PC  = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bp_enable,
  input  logic [31:0] if_pc,
  input  logic        if_stall,
  input  logic        ex_upd_valid,
  input  logic [31:0] ex_upd_pc,
  input  logic        ex_upd_taken,
  input  logic [31:0] ex_upd_target,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        bp_busy
);

  localparam int IDX_W = $clog2(ENTRIES);
`ifdef BP_BTB_TAG_EN
  localparam int TAG_W = TAG_WIDTH;
`else
  localparam int TAG_W = 0;
`endif
  localparam int ENTRY_W = 1 + TAG_W + 30 + CTR_WIDTH;
  // Cleared entries point at the fetch origin; they are invalid, so never predicted.
  localparam logic [29:0] INIT_TARGET = RESET_PC[31:2];

  if (ENTRIES < 4 || (ENTRIES & (ENTRIES - 1)) != 0 || CTR_WIDTH < 1 ||
      CTR_WIDTH > CTR_MAX_W || TAG_WIDTH < 1 || TAG_WIDTH > TAG_MAX_W ||
      IDX_W + TAG_WIDTH + 2 > 32) begin : g_bad_cfg
    $error("branch_predictor: unsupported parameter combination");
  end

  function automatic logic [ENTRY_W-1:0] entry_pack(input bp_entry_t e);
`ifdef BP_BTB_TAG_EN
    return {e.valid, e.tag[TAG_WIDTH-1:0], e.target, e.ctr[CTR_WIDTH-1:0]};
`else
    return {e.valid, e.target, e.ctr[CTR_WIDTH-1:0]};
`endif
  endfunction

  function automatic bp_entry_t entry_unpack(input logic [ENTRY_W-1:0] d);
    bp_entry_t e;
    e                    = '0;
    e.valid              = d[ENTRY_W-1];
    e.target             = d[CTR_WIDTH +: 30];
    e.ctr[CTR_WIDTH-1:0] = d[CTR_WIDTH-1:0];
`ifdef BP_BTB_TAG_EN
    e.tag[TAG_WIDTH-1:0] = d[CTR_WIDTH+30 +: TAG_WIDTH];
`endif
    return e;
  endfunction

  function automatic logic entry_says_taken(input bp_entry_t e);
    return e.valid & e.ctr[CTR_WIDTH-1];
  endfunction

  // ---------------------------------------------------------------- FSM
  bp_state_e        state_q, state_d;
  logic [IDX_W-1:0] init_ptr_q, init_ptr_d;
  logic             run;

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    case (state_q)
      BP_INIT: begin
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == IDX_W'(ENTRIES - 1)) begin
          state_d = BP_RUN;
        end
      end
      BP_RUN:  state_d = BP_RUN;
      default: state_d = BP_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= BP_INIT;
      init_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
    end
  end

  assign run     = (state_q == BP_RUN);
  assign bp_busy = (state_q == BP_INIT);

  // ---------------------------------------------------------------- lookup
  logic               lk_en;
  logic [IDX_W-1:0]   lk_idx;
  logic               lk_vld_q;
  logic               lk_bpen_q;
  logic               lk_hit;
  logic [ENTRY_W-1:0] rd_data;
  bp_entry_t          lk_entry;

  assign lk_en  = run & ~if_stall;
  assign lk_idx = IDX_W'(pc_index(if_pc, IDX_W));

  // A stalled cycle leaves every lookup register (and the table read register) untouched,
  // which is what holds pred_* steady.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lk_vld_q  <= 1'b0;
      lk_bpen_q <= 1'b0;
    end else if (!run) begin
      lk_vld_q  <= 1'b0;
    end else if (!if_stall) begin
      lk_vld_q  <= 1'b1;
      lk_bpen_q <= bp_enable;
    end
  end

`ifdef BP_BTB_TAG_EN
  tag_t lk_tag_q;

  always_ff @(posedge clk) begin
    if (lk_en) begin
      lk_tag_q <= pc_tag(if_pc, IDX_W, TAG_WIDTH);
    end
  end

  assign lk_hit = (lk_entry.tag == lk_tag_q);
`else
  assign lk_hit = 1'b1;
`endif

  assign lk_entry    = entry_unpack(rd_data);
  assign pred_taken  = lk_vld_q & lk_bpen_q & lk_hit & entry_says_taken(lk_entry);
  assign pred_target = lk_vld_q ? {lk_entry.target, 2'b00} : 32'h0;

  // ---------------------------------------------------------------- update
  logic [IDX_W-1:0]   upd_idx;
  logic [ENTRY_W-1:0] peek_data;
  bp_entry_t          upd_cur, upd_entry, init_entry;
  logic               upd_hit;
  logic [29:0]        upd_target;

  assign upd_idx    = IDX_W'(pc_index(ex_upd_pc, IDX_W));
  assign upd_cur    = entry_unpack(peek_data);
  assign upd_target = 30'(ex_upd_target >> 2);

`ifdef BP_BTB_TAG_EN
  tag_t upd_tag;
  assign upd_tag = pc_tag(ex_upd_pc, IDX_W, TAG_WIDTH);
  assign upd_hit = upd_cur.valid & (upd_cur.tag == upd_tag);
`else
  assign upd_hit = upd_cur.valid;
`endif

  always_comb begin
    upd_entry = upd_cur;
    if (upd_hit) begin
      if (ex_upd_taken) begin
        upd_entry.ctr    = ctr_inc(upd_cur.ctr, CTR_WIDTH);
        upd_entry.target = upd_target;
      end else begin
        upd_entry.ctr    = ctr_dec(upd_cur.ctr);
      end
    end else begin
      upd_entry        = '0;
      upd_entry.valid  = 1'b1;
`ifdef BP_BTB_TAG_EN
      upd_entry.tag    = upd_tag;
`endif
      upd_entry.target = upd_target;
      upd_entry.ctr    = ex_upd_taken ? ctr_weak_taken(CTR_WIDTH)
                                      : ctr_weak_not_taken(CTR_WIDTH);
    end
  end

  always_comb begin
    init_entry        = '0;
    init_entry.target = INIT_TARGET;
    init_entry.ctr    = ctr_weak_not_taken(CTR_WIDTH);
  end

  // INIT owns the write port; updates arriving during INIT are dropped.
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic [ENTRY_W-1:0] wr_data;

  assign wr_en   = rst & (bp_busy | (run & ex_upd_valid));
  assign wr_idx  = bp_busy ? init_ptr_q : upd_idx;
  assign wr_data = entry_pack(bp_busy ? init_entry : upd_entry);

  bp_table #(
    .ENTRIES (ENTRIES),
    .DATA_W  (ENTRY_W)
  ) u_table (
    .clk         (clk),
    .rd_en_i     (lk_en),
    .rd_idx_i    (lk_idx),
    .rd_data_o   (rd_data),
    .peek_idx_i  (upd_idx),
    .peek_data_o (peek_data),
    .wr_en_i     (wr_en),
    .wr_idx_i    (wr_idx),
    .wr_data_i   (wr_data)
  );

endmodule
